// File: rtl/multi_edge_detector.sv
// multi_edge_detector: N-channel debounced edge detector.
// Each channel synchronises its raw input, filters it with a stability counter,
// tracks the debounced level with a 4-state Moore FSM and raises a one-cycle
// tick plus a sticky pending flag on enabled edges. The pending flags OR into irq.

module med_channel #(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       level,
   input  logic [1:0] mode,
   input  logic       clr,
   output logic       tick,
   output logic       filt,
   output logic       pending
);

   localparam int CW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   typedef enum logic [1:0] {
      ZERO = 2'b00,
      RISE = 2'b01,
      ONE  = 2'b10,
      FALL = 2'b11
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [CW-1:0]          cnt_q, cnt_nxt;
   state_t                 state_q, state_nxt;
   logic                   rise_en, fall_en;

   // Synchroniser chain; the raw level enters bit 0 and leaves from the top bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], level};
   end

   assign s = sync_q[SYNC_STAGES-1];

   // State and stability counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ZERO;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   // Next state: count consecutive cycles where the synced level differs from
   // the accepted level; the counter restarts on any agreement and while in
   // the single-cycle RISE/FALL states.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = '0;
      case (state_q)
         ZERO: begin
            if (s) begin
               if (cnt_q == CNT_LAST) state_nxt = RISE;
               else                   cnt_nxt   = cnt_q + CW'(1);
            end
         end
         RISE: state_nxt = ONE;
         ONE: begin
            if (!s) begin
               if (cnt_q == CNT_LAST) state_nxt = FALL;
               else                   cnt_nxt   = cnt_q + CW'(1);
            end
         end
         FALL: state_nxt = ZERO;
         default: state_nxt = ZERO;
      endcase
   end

   // Moore outputs decoded from the state register; mode 11 masks both edges.
   assign rise_en = (mode == 2'b00) || (mode == 2'b10);
   assign fall_en = (mode == 2'b01) || (mode == 2'b10);
   assign filt    = (state_q == RISE) || (state_q == ONE);
   assign tick    = ((state_q == RISE) && rise_en) || ((state_q == FALL) && fall_en);

   // Sticky pending flag; a new tick wins over a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pending <= 1'b0;
      else       pending <= tick | (pending & ~clr);
   end

endmodule

module multi_edge_detector #(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   level,
   input  logic [2*N_CH-1:0] mode,
   input  logic [N_CH-1:0]   clr,
   output logic [N_CH-1:0]   tick,
   output logic [N_CH-1:0]   filt,
   output logic [N_CH-1:0]   pending,
   output logic              irq
);

   // One fully independent detector per channel.
   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      med_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEBOUNCE    (DEBOUNCE)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .level   (level[g]),
         .mode    (mode[2*g +: 2]),
         .clr     (clr[g]),
         .tick    (tick[g]),
         .filt    (filt[g]),
         .pending (pending[g])
      );
   end

   assign irq = |pending;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_multi_edge_detector;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] level;
   logic [7:0] mode;
   logic [3:0] clr;
   logic [3:0] tick;
   logic [3:0] filt;
   logic [3:0] pending;
   logic       irq;

   int n_checks = 0;
   int n_fail   = 0;

   multi_edge_detector dut (
      .clk     (clk),
      .reset   (reset),
      .level   (level),
      .mode    (mode),
      .clr     (clr),
      .tick    (tick),
      .filt    (filt),
      .pending (pending),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, ending on a falling edge.
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; level = '0; mode = '0; clr = '0;
      cyc(2);
      n_checks++;
      if ({tick, filt, pending, irq} !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_state: tick=%b filt=%b pending=%b irq=%b, want all 0", tick, filt, pending, irq);
      end
      reset = 1'b0;
      cyc(1);
   endtask

   // Test 1: channel 0 rise, tick exactly in the cycle after edge 6.
   task automatic test_rise();
      level[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         n_checks++;
         if (tick[0] !== (k == 6)) begin
            n_fail++;
            $display("FAIL rise_tick edge %0d: tick0=%b want %b", k, tick[0], (k == 6));
         end
      end
      n_checks++;
      if (filt[0] !== 1'b1 || pending[0] !== 1'b1 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL rise_flags: filt0=%b pending0=%b irq=%b want 1 1 1", filt[0], pending[0], irq);
      end
   endtask

   // Test 4: clear colliding with a tick loses; a lone clear wins.
   task automatic test_clr();
      clr[0] = 1'b1; cyc(1); clr[0] = 1'b0;
      level[0] = 1'b0; cyc(10);   // fall with mode 00: no tick
      n_checks++;
      if (pending[0] !== 1'b0 || filt[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_prep: pending0=%b filt0=%b want 0 0", pending[0], filt[0]);
      end
      level[0] = 1'b1;
      cyc(6);
      n_checks++;
      if (tick[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_tick: tick0=%b want 1", tick[0]);
      end
      clr[0] = 1'b1;
      cyc(1);
      n_checks++;
      if (pending[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_set_wins: pending0=%b want 1", pending[0]);
      end
      cyc(1);
      n_checks++;
      if (pending[0] !== 1'b0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_alone: pending0=%b irq=%b want 0 0", pending[0], irq);
      end
      clr[0] = 1'b0;
   endtask

   // Test 2: a 3-cycle pulse on channel 1 is rejected.
   task automatic test_glitch();
      level[1] = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         cyc(1);
         if (k == 3) level[1] = 1'b0;
         n_checks++;
         if (tick[1] !== 1'b0 || filt[1] !== 1'b0 || pending[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch edge %0d: tick1=%b filt1=%b pending1=%b want 0 0 0", k, tick[1], filt[1], pending[1]);
         end
      end
   endtask

   // Test 3: channel 2 in fall-only mode, then both-edges mode.
   task automatic test_modes();
      int nt;
      mode[5:4] = 2'b01;
      level[2] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         n_checks++;
         if (tick[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_mode_rise edge %0d: tick2=%b want 0", k, tick[2]);
         end
      end
      n_checks++;
      if (filt[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL fall_mode_filt: filt2=%b want 1", filt[2]);
      end
      level[2] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         n_checks++;
         if (tick[2] !== (k == 6)) begin
            n_fail++;
            $display("FAIL fall_mode_fall edge %0d: tick2=%b want %b", k, tick[2], (k == 6));
         end
      end
      mode[5:4] = 2'b10;
      nt = 0;
      for (int p = 0; p < 2; p++) begin
         level[2] = (p == 0);
         for (int k = 1; k <= 8; k++) begin
            cyc(1);
            if (tick[2]) nt++;
         end
      end
      n_checks++;
      if (nt != 2) begin
         n_fail++;
         $display("FAIL both_mode_count: ticks=%0d want 2", nt);
      end
      mode[5:4] = 2'b00;
      clr = 4'hf; cyc(1); clr = '0;
   endtask

   // Test 6: all channels together, enabled then masked.
   task automatic test_simultaneous();
      level = '0; cyc(10);
      clr = 4'hf; cyc(1); clr = '0;
      level = 4'hf;
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         n_checks++;
         if (tick !== ((k == 6) ? 4'hf : 4'h0)) begin
            n_fail++;
            $display("FAIL simul_tick edge %0d: tick=%b want %b", k, tick, ((k == 6) ? 4'hf : 4'h0));
         end
      end
      level = '0; cyc(10);
      clr = 4'hf; cyc(1); clr = '0;
      mode = 8'hff;
      level = 4'hf;
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         n_checks++;
         if (tick !== 4'h0) begin
            n_fail++;
            $display("FAIL masked_tick edge %0d: tick=%b want 0000", k, tick);
         end
      end
      n_checks++;
      if (filt !== 4'hf || pending !== 4'h0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL masked_flags: filt=%b pending=%b irq=%b want 1111 0000 0", filt, pending, irq);
      end
      level = '0; mode = '0; cyc(10);
   endtask

   // Test 5: reset mid-debounce on channel 3, then full latency after release.
   task automatic test_reset_mid();
      level[3] = 1'b1;
      cyc(4);                  // cnt = 2 after edge 4
      reset = 1'b1;
      #1;
      n_checks++;
      if ({tick, filt, pending, irq} !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_mid_async: tick=%b filt=%b pending=%b irq=%b want all 0", tick, filt, pending, irq);
      end
      cyc(1);
      reset = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         n_checks++;
         if (tick[3] !== (k == 6)) begin
            n_fail++;
            $display("FAIL reset_mid_latency edge %0d: tick3=%b want %b", k, tick[3], (k == 6));
         end
      end
      n_checks++;
      if (pending !== 4'b1000 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_pending: pending=%b irq=%b want 1000 1", pending, irq);
      end
   endtask

   initial begin
      test_reset();
      test_rise();
      test_clr();
      test_glitch();
      test_modes();
      test_simultaneous();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
